// File: rtl/dla_pool_window_pkg.sv
// Shared definitions for the 2x2 pooling window generator.
//   DLA_DATA_WID : default pixel width in bits (signed two's complement)
//   pool_state_e : one-hot state encoding of the window FSM
package dla_pkg;

   localparam int DLA_DATA_WID = 16;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0001,
      ST_ROW_TOP = 4'b0010,
      ST_ROW_BOT = 4'b0100,
      ST_DRAIN   = 4'b1000
   } pool_state_e;

endpackage

// File: rtl/dla_pool_window_if.sv
// Pixel-in / window-out stream bundle for dla_pool_window.
//   in_valid, in_data, in_ready   : raster-order pixel stream (valid/ready)
//   out_valid, out_ready          : 2x2 window handshake
//   dat_0..dat_3                  : window TL, TR, BL, BR
// master = stream producer/consumer side (bench or upstream), slave = window block.
interface dla_pool_window_if #(
   parameter int DATA_WID = dla_pkg::DLA_DATA_WID
);

   logic                in_valid;
   logic [DATA_WID-1:0] in_data;
   logic                in_ready;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_WID-1:0] dat_0;
   logic [DATA_WID-1:0] dat_1;
   logic [DATA_WID-1:0] dat_2;
   logic [DATA_WID-1:0] dat_3;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, dat_0, dat_1, dat_2, dat_3
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, dat_0, dat_1, dat_2, dat_3
   );

endinterface

// File: rtl/dla_pool_window_line_buf.sv
// dla_line_buf: one-row line buffer for the window generator.
//   clock, rst_n   : clock, async active-low reset (read register only)
//   i_wr_en/addr/data : single write port
//   i_rd_addr      : read address, sampled every cycle
//   o_rd_data      : registered read data (one cycle after i_rd_addr)
// Storage is not reset; only the output register is.
module dla_line_buf #(
   parameter int DATA_WID = 16,
   parameter int MAX_W    = 64,
   parameter int AW       = $clog2(MAX_W)
) (
   input  logic                clock,
   input  logic                rst_n,
   input  logic                i_wr_en,
   input  logic [AW-1:0]       i_wr_addr,
   input  logic [DATA_WID-1:0] i_wr_data,
   input  logic [AW-1:0]       i_rd_addr,
   output logic [DATA_WID-1:0] o_rd_data
);

   logic [DATA_WID-1:0] r_mem [MAX_W];
   logic [DATA_WID-1:0] r_rd_data;

   always_ff @(posedge clock) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dla_pool_window.sv
// dla_pool_window: turns a raster pixel stream into non-overlapping 2x2
// windows for a downstream pooling unit.
//   clock, rst_n          : clock, async active-low reset
//   start                 : pulse, latches cfg_width/cfg_height in IDLE
//   cfg_width, cfg_height : frame size in pixels/rows (even, 2..MAX)
//   pix_if (slave)        : pixel stream in, window stream out
//   busy                  : frame in progress
//   frame_done            : pulse after the last window is consumed
//   cfg_err               : pulse when a start is rejected
//   win_cnt               : windows consumed this frame, saturating
//                           (present only with DLA_POOL_WINDOW_CNT_EN)
//
// state      | meaning
// IDLE       | waiting for a start with a legal configuration
// ROW_TOP    | top row of a row pair, pixels go into the line buffer
// ROW_BOT    | bottom row, each odd column completes a window
// DRAIN      | no more input, waiting for the final window to be taken
module dla_pool_window
   import dla_pkg::*;
#(
   parameter int DATA_WID = DLA_DATA_WID,
   parameter int MAX_W    = 64,
   parameter int MAX_H    = 64
) (
   input  logic                       clock,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [$clog2(MAX_W+1)-1:0] cfg_width,
   input  logic [$clog2(MAX_H+1)-1:0] cfg_height,
   dla_pool_window_if.slave           pix_if,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       cfg_err
`ifdef DLA_POOL_WINDOW_CNT_EN
   ,
   output logic [15:0]                win_cnt
`endif
);

   localparam int CW = $clog2(MAX_W+1);
   localparam int HW = $clog2(MAX_H+1);
   localparam int AW = $clog2(MAX_W);

   pool_state_e         r_state;
   pool_state_e         w_state_nxt;
   logic [CW-1:0]       r_width;
   logic [CW-1:0]       r_col;
   logic [CW-1:0]       w_col_nxt;
   logic [HW-1:0]       r_pairs;
   logic [DATA_WID-1:0] r_tl;
   logic [DATA_WID-1:0] r_bl;
   logic [DATA_WID-1:0] r_dat0;
   logic [DATA_WID-1:0] r_dat1;
   logic [DATA_WID-1:0] r_dat2;
   logic [DATA_WID-1:0] r_dat3;
   logic                r_out_valid;
   logic                r_frame_done;
   logic                r_cfg_err;
   logic [DATA_WID-1:0] w_rd_data;
   logic                w_cfg_ok;
   logic                w_start_ok;
   logic                w_in_rdy;
   logic                w_acc;
   logic                w_row_end;
   logic                w_bot_end;
   logic                w_win_load;
   logic                w_out_hs;

   assign w_cfg_ok = !cfg_width[0]  && (cfg_width  >= CW'(2)) && (cfg_width  <= CW'(MAX_W)) &&
                     !cfg_height[0] && (cfg_height >= HW'(2)) && (cfg_height <= HW'(MAX_H));
   assign w_start_ok = (r_state == ST_IDLE) && start && w_cfg_ok;

   // The bottom row stalls only while a window is still waiting to be taken.
   assign w_in_rdy = (r_state == ST_ROW_TOP) ||
                     ((r_state == ST_ROW_BOT) && (!r_out_valid || pix_if.out_ready));
   assign w_acc      = pix_if.in_valid && w_in_rdy;
   assign w_row_end  = (r_col == r_width - CW'(1));
   assign w_bot_end  = (r_state == ST_ROW_BOT) && w_acc && w_row_end;
   assign w_win_load = (r_state == ST_ROW_BOT) && w_acc && r_col[0];
   assign w_out_hs   = r_out_valid && pix_if.out_ready;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_start_ok) w_state_nxt = ST_ROW_TOP;
         end
         ST_ROW_TOP: begin
            if (w_acc && w_row_end) w_state_nxt = ST_ROW_BOT;
         end
         ST_ROW_BOT: begin
            if (w_acc && w_row_end) begin
               w_state_nxt = (r_pairs == HW'(1)) ? ST_DRAIN : ST_ROW_TOP;
            end
         end
         ST_DRAIN: begin
            if (w_out_hs) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_col_nxt = r_col;
      if (w_start_ok) begin
         w_col_nxt = '0;
      end else if (w_acc) begin
         w_col_nxt = w_row_end ? '0 : r_col + CW'(1);
      end
   end

   // Reading at the upcoming column makes the registered read data line up
   // with the column of the pixel that will be accepted next.
   dla_line_buf #(
      .DATA_WID (DATA_WID),
      .MAX_W    (MAX_W),
      .AW       (AW)
   ) u_line_buf (
      .clock     (clock),
      .rst_n     (rst_n),
      .i_wr_en   ((r_state == ST_ROW_TOP) && w_acc),
      .i_wr_addr (r_col[AW-1:0]),
      .i_wr_data (pix_if.in_data),
      .i_rd_addr (w_col_nxt[AW-1:0]),
      .o_rd_data (w_rd_data)
   );

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_width      <= '0;
         r_col        <= '0;
         r_pairs      <= '0;
         r_tl         <= '0;
         r_bl         <= '0;
         r_dat0       <= '0;
         r_dat1       <= '0;
         r_dat2       <= '0;
         r_dat3       <= '0;
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         r_cfg_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_col   <= w_col_nxt;
         if (w_start_ok) begin
            r_width <= cfg_width;
            r_pairs <= cfg_height >> 1;
         end else if (w_bot_end) begin
            r_pairs <= r_pairs - HW'(1);
         end
         if ((r_state == ST_ROW_BOT) && w_acc && !r_col[0]) begin
            r_bl <= pix_if.in_data;
            r_tl <= w_rd_data;
         end
         if (w_win_load) begin
            r_dat0 <= r_tl;
            r_dat1 <= w_rd_data;
            r_dat2 <= r_bl;
            r_dat3 <= pix_if.in_data;
         end
         if (w_win_load) begin
            r_out_valid <= 1'b1;
         end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
         end
         r_frame_done <= (r_state == ST_DRAIN) && w_out_hs;
         r_cfg_err    <= (r_state == ST_IDLE) && start && !w_cfg_ok;
      end
   end

`ifdef DLA_POOL_WINDOW_CNT_EN
   logic [15:0] r_win_cnt;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_win_cnt <= '0;
      end else if (w_start_ok) begin
         r_win_cnt <= '0;
      end else if (w_out_hs && (r_win_cnt != 16'hFFFF)) begin
         r_win_cnt <= r_win_cnt + 16'd1;
      end
   end

   assign win_cnt = r_win_cnt;
`endif

   assign pix_if.in_ready  = w_in_rdy;
   assign pix_if.out_valid = r_out_valid;
   assign pix_if.dat_0     = r_dat0;
   assign pix_if.dat_1     = r_dat1;
   assign pix_if.dat_2     = r_dat2;
   assign pix_if.dat_3     = r_dat3;
   assign busy             = (r_state != ST_IDLE);
   assign frame_done       = r_frame_done;
   assign cfg_err          = r_cfg_err;

endmodule

// File: tb/tb_dla_pool_window.sv
// Scoreboard bench for dla_pool_window: expected windows are queued when a
// frame is issued, a negedge monitor pops and compares on every handshake.
module tb_dla_pool_window;
   import dla_pkg::*;

   localparam int DW = 16;
   localparam int MW = 64;
   localparam int MH = 64;
   localparam int CW = $clog2(MW+1);
   localparam int HW = $clog2(MH+1);

   logic          clock = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] cfg_width = '0;
   logic [HW-1:0] cfg_height = '0;
   logic          busy;
   logic          frame_done;
   logic          cfg_err;
`ifdef DLA_POOL_WINDOW_CNT_EN
   logic [15:0]   win_cnt;
`endif

   dla_pool_window_if #(.DATA_WID(DW)) pix_if ();

   dla_pool_window #(
      .DATA_WID (DW),
      .MAX_W    (MW),
      .MAX_H    (MH)
   ) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .start      (start),
      .cfg_width  (cfg_width),
      .cfg_height (cfg_height),
      .pix_if     (pix_if),
      .busy       (busy),
      .frame_done (frame_done),
      .cfg_err    (cfg_err)
`ifdef DLA_POOL_WINDOW_CNT_EN
      ,
      .win_cnt    (win_cnt)
`endif
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic [DW-1:0] d2;
      logic [DW-1:0] d3;
   } win_t;

   win_t          exp_q[$];
   win_t          m_exp;
   win_t          m_got;
   int            n_checks = 0;
   int            n_errors = 0;
   int            n_win = 0;
   int            n_done = 0;
   int            n_cfg_err = 0;
   bit            pend_done = 0;
   bit            tog_stop = 0;
   logic [DW-1:0] pix [64];

   // Monitor: window scoreboard plus frame_done timing.
   always @(negedge clock) begin
      if (!rst_n) begin
         pend_done = 0;
      end else begin
         if (pend_done) begin
            n_checks++;
            if (frame_done !== 1'b1 || busy !== 1'b0) begin
               n_errors++;
               $display("FAIL frame_done after last window: got done=%0b busy=%0b, need done=1 busy=0",
                        frame_done, busy);
            end
            pend_done = 0;
         end else if (frame_done === 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL frame_done: unexpected pulse, need 0");
         end
         if (frame_done === 1'b1) n_done++;
         if (cfg_err === 1'b1) n_cfg_err++;
         if (pix_if.out_valid === 1'b1 && pix_if.out_ready === 1'b1) begin
            n_checks++;
            n_win++;
            m_got = {pix_if.dat_0, pix_if.dat_1, pix_if.dat_2, pix_if.dat_3};
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL window: got unexpected (%0d,%0d,%0d,%0d), need none",
                        $signed(m_got.d0), $signed(m_got.d1), $signed(m_got.d2), $signed(m_got.d3));
            end else begin
               m_exp = exp_q.pop_front();
               if (m_got !== m_exp) begin
                  n_errors++;
                  $display("FAIL window %0d: got (%0d,%0d,%0d,%0d), need (%0d,%0d,%0d,%0d)", n_win,
                           $signed(m_got.d0), $signed(m_got.d1), $signed(m_got.d2), $signed(m_got.d3),
                           $signed(m_exp.d0), $signed(m_exp.d1), $signed(m_exp.d2), $signed(m_exp.d3));
               end
               if (exp_q.size() == 0) pend_done = 1;
            end
         end
      end
   end

   task automatic check(input string nm, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, need %0d", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input int a, input int b, input int c, input int d);
      win_t w;
      w.d0 = a[DW-1:0];
      w.d1 = b[DW-1:0];
      w.d2 = c[DW-1:0];
      w.d3 = d[DW-1:0];
      exp_q.push_back(w);
   endtask

   task automatic do_start(input int w, input int h);
      cfg_width  = w[CW-1:0];
      cfg_height = h[HW-1:0];
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic send_pix(input int v);
      bit acc;
      int k;
      acc = 0;
      k   = 0;
      pix_if.in_valid = 1'b1;
      pix_if.in_data  = v[DW-1:0];
      while (!acc && k < 500) begin
         @(negedge clock);
         acc = pix_if.in_ready;
         tick();
         k++;
      end
      pix_if.in_valid = 1'b0;
      if (!acc) begin
         n_checks++;
         n_errors++;
         $display("FAIL pixel accept timeout: got no in_ready, need accept of %0d", v);
      end
   endtask

   task automatic wait_done(input int target);
      int k;
      k = 0;
      while (n_done < target && k < 2000) begin
         @(negedge clock);
         k++;
      end
      if (n_done < target) begin
         n_checks++;
         n_errors++;
         $display("FAIL frame_done timeout: got %0d frames, need %0d", n_done, target);
      end
   endtask

   initial begin
      int w0;
      int d0;
      int e0;
      bit seen;
      int k;
      longint cap;

      pix_if.in_valid  = 1'b0;
      pix_if.in_data   = '0;
      pix_if.out_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clock);
      check("reset in_ready", pix_if.in_ready, 0);
      check("reset out_valid", pix_if.out_valid, 0);
      check("reset dat", {pix_if.dat_0, pix_if.dat_1, pix_if.dat_2, pix_if.dat_3}, 0);
      check("reset busy/done/err", {busy, frame_done, cfg_err}, 0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // 4x2 frame, pixels 1..8, consumer always ready
      pix_if.out_ready = 1'b1;
      push(1, 2, 5, 6);
      push(3, 4, 7, 8);
      d0 = n_done;
      do_start(4, 2);
      @(negedge clock);
      check("busy after start", busy, 1);
      tick();
      for (int i = 1; i <= 8; i++) send_pix(i);
      wait_done(d0 + 1);
`ifdef DLA_POOL_WINDOW_CNT_EN
      check("win_cnt 4x2", win_cnt, 2);
`endif
      tick();

      // 4x4 frame with a 3-cycle stall on the first window
      pix_if.out_ready = 1'b0;
      push(1, 2, 5, 6);
      push(3, 4, 7, 8);
      push(9, 10, 13, 14);
      push(11, 12, 15, 16);
      w0 = n_win;
      d0 = n_done;
      do_start(4, 4);
      fork
         begin
            for (int i = 1; i <= 16; i++) send_pix(i);
         end
         begin
            seen = 0;
            k = 0;
            while (!seen && k < 500) begin
               @(negedge clock);
               seen = pix_if.out_valid;
               k++;
            end
            check("stall first window seen", seen, 1);
            cap = {pix_if.dat_0, pix_if.dat_1, pix_if.dat_2, pix_if.dat_3};
            check("stall captured window", cap, {16'd1, 16'd2, 16'd5, 16'd6});
            for (int j = 0; j < 3; j++) begin
               check("stall in_ready", pix_if.in_ready, 0);
               check("stall dat stable", {pix_if.dat_0, pix_if.dat_1, pix_if.dat_2, pix_if.dat_3}, cap);
               if (j < 2) @(negedge clock);
            end
            tick();
            pix_if.out_ready = 1'b1;
         end
      join
      wait_done(d0 + 1);
      check("windows 4x4", n_win - w0, 4);
      tick();

      // Rejected configurations
      do_start(3, 2);
      @(negedge clock);
      check("cfg_err width 3", cfg_err, 1);
      check("busy after bad start", busy, 0);
      @(negedge clock);
      check("cfg_err one cycle", cfg_err, 0);
      tick();
      do_start(MW + 2, 2);
      @(negedge clock);
      check("cfg_err width MAX_W+2", cfg_err, 1);
      tick();
      do_start(4, 3);
      @(negedge clock);
      check("cfg_err height 3", cfg_err, 1);
      tick();

      // Reset mid-frame, then a 2x2 negative frame
      do_start(4, 4);
      for (int i = 1; i <= 5; i++) send_pix(i * 3);
      check("busy mid-frame", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid reset in_ready/out_valid", {pix_if.in_ready, pix_if.out_valid}, 0);
      check("mid reset dat", {pix_if.dat_0, pix_if.dat_1, pix_if.dat_2, pix_if.dat_3}, 0);
      check("mid reset busy/done/err", {busy, frame_done, cfg_err}, 0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      push(-1, -2, -3, -4);
      d0 = n_done;
      do_start(2, 2);
      send_pix(-1);
      send_pix(-2);
      send_pix(-3);
      send_pix(-4);
      wait_done(d0 + 1);
      tick();

      // 8x8 random frame, consumer toggling; stray starts mid-frame ignored
      for (int i = 0; i < 64; i++) pix[i] = DW'($urandom_range(0, 65535));
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            exp_q.push_back({pix[(2*r)*8 + 2*c], pix[(2*r)*8 + 2*c + 1],
                             pix[(2*r+1)*8 + 2*c], pix[(2*r+1)*8 + 2*c + 1]});
         end
      end
      w0 = n_win;
      d0 = n_done;
      e0 = n_cfg_err;
      pix_if.out_ready = 1'b1;
      tog_stop = 0;
      do_start(8, 8);
      fork
         begin
            while (!tog_stop) begin
               tick();
               pix_if.out_ready = ~pix_if.out_ready;
            end
         end
         begin
            for (int i = 0; i < 64; i++) begin
               send_pix(int'(pix[i]));
               if (i == 10) do_start(3, 2);
               if (i == 30) do_start(2, 2);
            end
            wait_done(d0 + 1);
            tog_stop = 1;
         end
      join
      check("windows 8x8", n_win - w0, 16);
      check("no cfg_err while busy", n_cfg_err - e0, 0);
      check("busy after 8x8", busy, 0);
`ifdef DLA_POOL_WINDOW_CNT_EN
      check("win_cnt 8x8", win_cnt, 16);
`endif
      check("scoreboard empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
